// File: rtl/asip_pkg.sv
// Shared types and sizing for the decode-stage hazard scoreboard.
package asip_pkg;

   localparam int NREGS        = 16;
   localparam int REG_W        = $clog2(NREGS);
   localparam int MAX_INFLIGHT = 4;
   localparam int CNT_W        = 16;
   localparam int INF_W        = $clog2(MAX_INFLIGHT + 1);

   typedef logic [REG_W-1:0] reg_idx_t;

   // Decoded register usage of the instruction sitting in decode.
   // en = {rs2_en, rs1_en}, we = {we_vec, we_sc}.
   typedef struct packed {
      reg_idx_t   rs1;
      reg_idx_t   rs2;
      logic [1:0] en;
      logic       vec;
      reg_idx_t   rd;
      logic [1:0] we;
   } dec_hazard_t;

endpackage

// File: rtl/scoreboard_bank.sv
// Pending-write bit vector for one register file, with same-cycle writeback bypass on its read ports.
module scoreboard_bank
   import asip_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     set_en,
   input  reg_idx_t set_idx,
   input  logic     clr_en,
   input  reg_idx_t clr_idx,
   input  reg_idx_t src1_idx,
   input  reg_idx_t src2_idx,
   input  reg_idx_t dst_idx,
   output logic     src1_busy,
   output logic     src2_busy,
   output logic     dst_busy,
   output logic     retire
);

   logic [NREGS-1:0] pend;
   logic [NREGS-1:0] eff;

   // NOTE: eff gets a full default before the conditional clear, so no latch is inferred.
   always_comb begin
      eff = pend;
      if (clr_en) eff[clr_idx] = 1'b0;
   end

   assign src1_busy = eff[src1_idx];
   assign src2_busy = eff[src2_idx];
   assign dst_busy  = eff[dst_idx];
   assign retire    = clr_en & pend[clr_idx];

   // NOTE: non-blocking assignments; the later set overrides the earlier clear of the same bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend <= '0;
      end else begin
         if (clr_en) pend[clr_idx] <= 1'b0;
         if (set_en) pend[set_idx] <= 1'b1;
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: stalls/bubbles on RAW, WAW or full in-flight capacity, tracks retires.
module hazard_scoreboard
   import asip_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             dec_valid,
   input  logic [REG_W-1:0] dec_rs1,
   input  logic [REG_W-1:0] dec_rs2,
   input  logic             dec_rs1_en,
   input  logic             dec_rs2_en,
   input  logic             dec_rs_vec,
   input  logic [REG_W-1:0] dec_rd,
   input  logic             dec_we_sc,
   input  logic             dec_we_vec,
   input  logic             flush,
   input  logic             wb_valid,
   input  logic [REG_W-1:0] wb_rd,
   input  logic             wb_vec,
   output logic             stall,
   output logic             bubble,
   output logic             issue,
   output logic             idle,
   output logic [CNT_W-1:0] stall_cycles
);

   dec_hazard_t      dec;
   logic [INF_W-1:0] inflight;
   logic sc_src1, sc_src2, sc_dst, sc_retire;
   logic vec_src1, vec_src2, vec_dst, vec_retire;
   logic go, writes, retire, raw, waw, full, hazard, issue_w;

   assign dec = '{rs1: dec_rs1, rs2: dec_rs2, en: {dec_rs2_en, dec_rs1_en},
                  vec: dec_rs_vec, rd: dec_rd, we: {dec_we_vec, dec_we_sc}};

   scoreboard_bank u_sc (
      .clk       (clk),
      .reset     (reset),
      .set_en    (issue & dec.we[0]),
      .set_idx   (dec.rd),
      .clr_en    (wb_valid & ~wb_vec),
      .clr_idx   (wb_rd),
      .src1_idx  (dec.rs1),
      .src2_idx  (dec.rs2),
      .dst_idx   (dec.rd),
      .src1_busy (sc_src1),
      .src2_busy (sc_src2),
      .dst_busy  (sc_dst),
      .retire    (sc_retire)
   );

   scoreboard_bank u_vec (
      .clk       (clk),
      .reset     (reset),
      .set_en    (issue & dec.we[1]),
      .set_idx   (dec.rd),
      .clr_en    (wb_valid & wb_vec),
      .clr_idx   (wb_rd),
      .src1_idx  (dec.rs1),
      .src2_idx  (dec.rs2),
      .dst_idx   (dec.rd),
      .src1_busy (vec_src1),
      .src2_busy (vec_src2),
      .dst_busy  (vec_dst),
      .retire    (vec_retire)
   );

   assign go     = dec_valid & ~flush;
   assign writes = |dec.we;
   assign retire = sc_retire | vec_retire;
   assign raw    = dec.vec ? ((dec.en[0] & vec_src1) | (dec.en[1] & vec_src2))
                           : ((dec.en[0] & sc_src1)  | (dec.en[1] & sc_src2));
   assign waw    = (dec.we[0] & sc_dst) | (dec.we[1] & vec_dst);
   // A retire this cycle frees a slot, so capacity is judged on inflight - retire.
   assign full   = writes & (inflight == INF_W'(MAX_INFLIGHT)) & ~retire;
   assign hazard = go & (raw | waw | full);

   assign stall   = hazard;
   assign issue   = go & ~hazard;
   assign bubble  = ~issue;
   assign idle    = (inflight == '0);
   assign issue_w = issue & writes;

   always_ff @(posedge clk) begin
      if (reset) begin
         inflight     <= '0;
         stall_cycles <= '0;
      end else begin
         if (issue_w && !retire)
            inflight <= inflight + 1'b1;
         else if (!issue_w && retire && inflight != '0)
            inflight <= inflight - 1'b1;
         if (stall && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: per-cycle expected flags queued with stimulus, popped at sample time.
module tb_hazard_scoreboard;
   import asip_pkg::*;

   logic             clk = 1'b0;
   logic             reset;
   logic             dec_valid, dec_rs1_en, dec_rs2_en, dec_rs_vec, dec_we_sc, dec_we_vec;
   reg_idx_t         dec_rs1, dec_rs2, dec_rd, wb_rd;
   logic             flush, wb_valid, wb_vec;
   logic             stall, bubble, issue, idle;
   logic [CNT_W-1:0] stall_cycles;

   int               tests  = 0;
   int               failed = 0;
   logic [CNT_W-1:0] exp_cnt;
   logic [3:0]       exp_q[$];

   typedef struct {
      logic dv; reg_idx_t rs1; logic e1; reg_idx_t rs2; logic e2; logic vec;
      reg_idx_t rd; logic wsc, wvec, fl, wbv; reg_idx_t wbrd; logic wbvec;
      logic st, is, id;
   } step_t;

   hazard_scoreboard dut (
      .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_rs1_en(dec_rs1_en), .dec_rs2_en(dec_rs2_en), .dec_rs_vec(dec_rs_vec), .dec_rd(dec_rd),
      .dec_we_sc(dec_we_sc), .dec_we_vec(dec_we_vec), .flush(flush), .wb_valid(wb_valid),
      .wb_rd(wb_rd), .wb_vec(wb_vec), .stall(stall), .bubble(bubble), .issue(issue),
      .idle(idle), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   function automatic step_t mk(int dv, int rs1, int e1, int rs2, int e2, int vec, int rd,
                                int wsc, int wvec, int fl, int wbv, int wbrd, int wbvec,
                                int st, int is, int id);
      step_t s;
      s.dv = 1'(dv); s.rs1 = reg_idx_t'(rs1); s.e1 = 1'(e1); s.rs2 = reg_idx_t'(rs2);
      s.e2 = 1'(e2); s.vec = 1'(vec); s.rd = reg_idx_t'(rd); s.wsc = 1'(wsc);
      s.wvec = 1'(wvec); s.fl = 1'(fl); s.wbv = 1'(wbv); s.wbrd = reg_idx_t'(wbrd);
      s.wbvec = 1'(wbvec); s.st = 1'(st); s.is = 1'(is); s.id = 1'(id);
      return s;
   endfunction

   task automatic clear_inputs();
      dec_valid = 0; dec_rs1 = '0; dec_rs2 = '0; dec_rs1_en = 0; dec_rs2_en = 0;
      dec_rs_vec = 0; dec_rd = '0; dec_we_sc = 0; dec_we_vec = 0; flush = 0;
      wb_valid = 0; wb_rd = '0; wb_vec = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1;
      tick();
      tick();
      reset = 0;
      exp_cnt = '0;
   endtask

   // Drive one decode cycle, queue its expected {stall,bubble,issue,idle}, wait to the sample point.
   task automatic apply(input step_t s);
      dec_valid = s.dv; dec_rs1 = s.rs1; dec_rs1_en = s.e1; dec_rs2 = s.rs2; dec_rs2_en = s.e2;
      dec_rs_vec = s.vec; dec_rd = s.rd; dec_we_sc = s.wsc; dec_we_vec = s.wvec; flush = s.fl;
      wb_valid = s.wbv; wb_rd = s.wbrd; wb_vec = s.wbvec;
      exp_q.push_back({s.st, ~s.is, s.is, s.id});
      if (s.st) exp_cnt = exp_cnt + 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [3:0] got;
      clear_inputs();
      reset = 1;
      tick();
      tick();
      @(negedge clk);
      got = {stall, bubble, issue, idle};
      tests++;
      if (got !== 4'b0101) begin
         failed++;
         $display("FAIL reset_flags: {stall,bubble,issue,idle} got %b expected 0101", got);
      end
      tests++;
      if (stall_cycles !== '0) begin
         failed++;
         $display("FAIL reset_cnt: stall_cycles got %0d expected 0", stall_cycles);
      end
      tick();
      reset = 0;
      exp_cnt = '0;
   endtask

   task automatic test_raw();
      step_t seq[$];
      logic [3:0] got, exp;
      do_reset();
      seq.push_back(mk(1,0,0,0,0,0,3,1,0,0,0,0,0, 0,1,1));
      seq.push_back(mk(1,3,1,0,0,0,0,0,0,0,0,0,0, 1,0,0));
      seq.push_back(mk(1,3,1,0,0,0,0,0,0,0,1,3,1, 1,0,0));
      seq.push_back(mk(1,3,1,0,0,0,0,0,0,0,1,3,0, 0,1,0));
      seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,1));
      seq.push_back(mk(1,0,0,0,0,0,9,1,0,0,0,0,0, 0,1,1));
      seq.push_back(mk(1,0,0,9,1,1,0,0,0,0,0,0,0, 0,1,0));
      seq.push_back(mk(1,0,0,9,1,0,0,0,0,0,0,0,0, 1,0,0));
      seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,9,0, 0,0,0));
      seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,1));
      foreach (seq[i]) begin
         apply(seq[i]);
         exp = exp_q.pop_front();
         got = {stall, bubble, issue, idle};
         tests++;
         if (got !== exp) begin
            failed++;
            $display("FAIL raw[%0d]: {stall,bubble,issue,idle} got %b expected %b", i, got, exp);
         end
         tick();
      end
      tests++;
      if (stall_cycles !== exp_cnt) begin
         failed++;
         $display("FAIL raw_cnt: stall_cycles got %0d expected %0d", stall_cycles, exp_cnt);
      end
   endtask

   task automatic test_waw_vec();
      step_t seq[$];
      logic [3:0] got, exp;
      do_reset();
      seq.push_back(mk(1,0,0,0,0,0,5,0,1,0,0,0,0, 0,1,1));
      seq.push_back(mk(1,0,0,0,0,0,5,0,1,0,0,0,0, 1,0,0));
      seq.push_back(mk(1,5,1,0,0,0,0,0,0,0,0,0,0, 0,1,0));
      seq.push_back(mk(1,0,0,0,0,0,5,1,0,0,0,0,0, 0,1,0));
      seq.push_back(mk(1,5,1,0,0,1,0,0,0,0,0,0,0, 1,0,0));
      seq.push_back(mk(1,0,0,0,0,0,5,0,1,0,1,5,1, 0,1,0));
      seq.push_back(mk(1,5,1,0,0,1,0,0,0,0,0,0,0, 1,0,0));
      seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,5,1, 0,0,0));
      seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,5,0, 0,0,0));
      seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,1));
      foreach (seq[i]) begin
         apply(seq[i]);
         exp = exp_q.pop_front();
         got = {stall, bubble, issue, idle};
         tests++;
         if (got !== exp) begin
            failed++;
            $display("FAIL waw_vec[%0d]: {stall,bubble,issue,idle} got %b expected %b", i, got, exp);
         end
         tick();
      end
      tests++;
      if (stall_cycles !== exp_cnt) begin
         failed++;
         $display("FAIL waw_vec_cnt: stall_cycles got %0d expected %0d", stall_cycles, exp_cnt);
      end
   endtask

   task automatic test_capacity();
      step_t seq[$];
      logic [3:0] got, exp;
      do_reset();
      for (int r = 1; r <= 4; r++) seq.push_back(mk(1,0,0,0,0,0,r,1,0,0,0,0,0, 0,1,(r == 1)));
      seq.push_back(mk(1,0,0,0,0,0,6,1,0,0,0,0,0, 1,0,0));
      seq.push_back(mk(1,0,0,0,0,0,6,1,0,0,1,1,0, 0,1,0));
      seq.push_back(mk(1,0,0,0,0,0,8,1,0,0,0,0,0, 1,0,0));
      seq.push_back(mk(1,0,0,0,0,0,8,0,1,0,0,0,0, 1,0,0));
      seq.push_back(mk(1,10,1,0,0,0,0,0,0,0,0,0,0, 0,1,0));
      seq.push_back(mk(1,0,0,0,0,0,8,1,0,0,1,1,0, 1,0,0));
      seq.push_back(mk(1,0,0,0,0,0,8,1,1,0,1,2,0, 0,1,0));
      seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,3,0, 0,0,0));
      seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,4,0, 0,0,0));
      seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,6,0, 0,0,0));
      seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,8,0, 0,0,0));
      seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,8,1, 0,0,1));
      seq.push_back(mk(1,0,0,0,0,0,11,1,0,0,0,0,0, 0,1,1));
      seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0));
      seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,11,0, 0,0,0));
      seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,1));
      foreach (seq[i]) begin
         apply(seq[i]);
         exp = exp_q.pop_front();
         got = {stall, bubble, issue, idle};
         tests++;
         if (got !== exp) begin
            failed++;
            $display("FAIL capacity[%0d]: {stall,bubble,issue,idle} got %b expected %b", i, got, exp);
         end
         tick();
      end
      tests++;
      if (stall_cycles !== exp_cnt) begin
         failed++;
         $display("FAIL capacity_cnt: stall_cycles got %0d expected %0d", stall_cycles, exp_cnt);
      end
   endtask

   task automatic test_back_to_back();
      step_t seq[$];
      logic [3:0] got, exp;
      do_reset();
      seq.push_back(mk(1,0,0,0,0,0,7,1,0,0,0,0,0, 0,1,1));
      seq.push_back(mk(1,0,0,0,0,0,7,1,0,0,1,7,0, 0,1,0));
      seq.push_back(mk(1,7,1,0,0,0,0,0,0,0,0,0,0, 1,0,0));
      seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,7,0, 0,0,0));
      seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,1));
      foreach (seq[i]) begin
         apply(seq[i]);
         exp = exp_q.pop_front();
         got = {stall, bubble, issue, idle};
         tests++;
         if (got !== exp) begin
            failed++;
            $display("FAIL collision[%0d]: {stall,bubble,issue,idle} got %b expected %b", i, got, exp);
         end
         tick();
      end
   endtask

   task automatic test_flush();
      step_t seq[$];
      logic [3:0] got, exp;
      do_reset();
      seq.push_back(mk(1,0,0,0,0,0,2,1,0,0,0,0,0, 0,1,1));
      seq.push_back(mk(1,2,1,0,0,0,0,0,0,1,0,0,0, 0,0,0));
      seq.push_back(mk(1,2,1,0,0,0,0,0,0,0,0,0,0, 1,0,0));
      seq.push_back(mk(1,0,0,0,0,0,12,1,0,1,0,0,0, 0,0,0));
      seq.push_back(mk(1,12,1,0,0,0,0,0,0,0,0,0,0, 0,1,0));
      seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,2,0, 0,0,0));
      seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,1));
      foreach (seq[i]) begin
         apply(seq[i]);
         exp = exp_q.pop_front();
         got = {stall, bubble, issue, idle};
         tests++;
         if (got !== exp) begin
            failed++;
            $display("FAIL flush[%0d]: {stall,bubble,issue,idle} got %b expected %b", i, got, exp);
         end
         tick();
      end
      tests++;
      if (stall_cycles !== exp_cnt) begin
         failed++;
         $display("FAIL flush_cnt: stall_cycles got %0d expected %0d", stall_cycles, exp_cnt);
      end
   endtask

   task automatic test_reset_midop();
      step_t seq[$];
      logic [3:0] got, exp;
      do_reset();
      seq.push_back(mk(1,0,0,0,0,0,1,1,0,0,0,0,0, 0,1,1));
      seq.push_back(mk(1,0,0,0,0,0,2,1,0,0,0,0,0, 0,1,0));
      seq.push_back(mk(1,0,0,0,0,0,3,1,0,0,0,0,0, 0,1,0));
      seq.push_back(mk(1,1,1,0,0,0,0,0,0,0,0,0,0, 1,0,0));
      // Reset is pulsed here, between the two halves of the table.
      seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,1));
      seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,1,0, 0,0,1));
      seq.push_back(mk(1,1,1,0,0,0,0,0,0,0,0,0,0, 0,1,1));
      seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,1));
      foreach (seq[i]) begin
         if (i == 4) begin
            reset = 1;
            tick();
            reset = 0;
            exp_cnt = '0;
         end
         apply(seq[i]);
         exp = exp_q.pop_front();
         got = {stall, bubble, issue, idle};
         tests++;
         if (got !== exp) begin
            failed++;
            $display("FAIL reset_midop[%0d]: {stall,bubble,issue,idle} got %b expected %b", i, got, exp);
         end
         tick();
      end
      tests++;
      if (stall_cycles !== exp_cnt) begin
         failed++;
         $display("FAIL reset_midop_cnt: stall_cycles got %0d expected %0d", stall_cycles, exp_cnt);
      end
   endtask

   task automatic test_saturate();
      logic [CNT_W-1:0] all_ones;
      all_ones = '1;
      do_reset();
      dec_valid = 1; dec_rd = 4'd0; dec_we_sc = 1;
      tick();
      dec_we_sc = 0; dec_rs1 = 4'd0; dec_rs1_en = 1;
      repeat (100) tick();
      @(negedge clk);
      tests++;
      if (stall_cycles !== CNT_W'(100) || stall !== 1'b1) begin
         failed++;
         $display("FAIL sat_count: stall_cycles got %0d stall %b expected 100 stall 1", stall_cycles, stall);
      end
      repeat (65500) tick();
      @(negedge clk);
      tests++;
      if (stall_cycles !== all_ones) begin
         failed++;
         $display("FAIL sat_cap: stall_cycles got %0d expected %0d", stall_cycles, all_ones);
      end
      do_reset();
   endtask

   initial begin
      reset = 1;
      exp_cnt = '0;
      clear_inputs();
      test_reset();
      test_raw();
      test_waw_vec();
      test_capacity();
      test_back_to_back();
      test_flush();
      test_reset_midop();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
